// File: rtl/prog_mem_loader_pkg.sv
// Shared definitions for the program memory loader: FSM states, fill value and the
// control-unit opcodes that consume an operand byte.
package prog_mem_loader_pkg;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2
  } state_e;

  localparam logic [7:0] NopInstr = 8'hFF;

  localparam logic [3:0] OpClr  = 4'hA;
  localparam logic [3:0] OpLoad = 4'hB;
  localparam logic [3:0] OpJmp  = 4'hC;
  localparam logic [3:0] OpJc   = 4'hD;

  // Ops whose second byte is fetched from the data port.
  function automatic logic is_two_cycle(input logic [7:0] instr);
    return (instr[7:4] == OpLoad) || (instr[7:4] == OpJmp) || (instr[7:4] == OpJc);
  endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Bus between the control unit / byte-stream loader (master) and the program memory (slave).
interface prog_mem_loader_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] address;
  logic [DW-1:0] instruction;
  logic [DW-1:0] data;
  logic          cpu_hold;
  logic          load_en;
  logic          load_valid;
  logic [DW-1:0] load_byte;
  logic          load_ready;
  logic [AW:0]   prog_len;
  logic          busy;

  modport master (
    output address, load_en, load_valid, load_byte,
    input  instruction, data, cpu_hold, load_ready, prog_len, busy
  );

  modport slave (
    input  address, load_en, load_valid, load_byte,
    output instruction, data, cpu_hold, load_ready, prog_len, busy
  );
endinterface

// File: rtl/prog_mem_array.sv
// 2**AW x DW storage: one synchronous write port, registered reads of addr and addr+1.
module prog_mem_array #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o
);
  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata0_d, rdata0_q;
  logic [DW-1:0] rdata1_d, rdata1_q;

  // addr+1 wraps naturally at AW bits.
  always_comb begin
    raddr1   = raddr_i + 1'b1;
    rdata0_d = mem_q[raddr_i];
    rdata1_d = mem_q[raddr1];
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata0_q <= rdata0_d;
    rdata1_q <= rdata1_d;
  end

  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory with a byte-stream loader: sweeps to NOP, optionally loads a program,
// then serves instruction/operand fetches while the CPU runs.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int unsigned   AW    = 8,
  parameter int unsigned   DEPTH = 256,
  parameter int unsigned   DW    = 8,
  parameter logic [DW-1:0] NOP   = DW'(NopInstr)
) (
  input logic               clk,
  input logic               rst,
  prog_mem_loader_if.slave  mem_bus
);
  localparam int unsigned PtrW = AW + 1;

  state_e          state_q, state_d;
  logic [AW:0]     ptr_q, ptr_d;
  logic [AW:0]     prog_len_q, prog_len_d;
  logic            sel_q, sel_d;

  logic            full;
  logic            accept;
  logic            we;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rd_instr;
  logic [DW-1:0]   rd_data;

  // ptr reaching DEPTH sets the top bit.
  assign full   = ptr_q[AW];
  assign accept = (state_q == StLoad) && mem_bus.load_en && mem_bus.load_valid && !full;
  assign we     = (state_q == StClear) || accept;
  assign wdata  = (state_q == StClear) ? NOP : mem_bus.load_byte;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    prog_len_d = prog_len_q;
    // Read data registered this cycle is only exposed if it was fetched while running.
    sel_d      = (state_q == StRun);
    unique case (state_q)
      StClear: begin
        if (ptr_q == PtrW'(DEPTH - 1)) begin
          ptr_d   = '0;
          state_d = mem_bus.load_en ? StLoad : StRun;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StLoad: begin
        if (!mem_bus.load_en) begin
          state_d    = StRun;
          prog_len_d = ptr_q;
        end else if (accept) begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StRun: begin
        if (mem_bus.load_en) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = StClear;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      ptr_q      <= '0;
      prog_len_q <= '0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      prog_len_q <= prog_len_d;
      sel_q      <= sel_d;
    end
  end

  prog_mem_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk_i    (clk),
    .we_i     (we),
    .waddr_i  (ptr_q[AW-1:0]),
    .wdata_i  (wdata),
    .raddr_i  (mem_bus.address),
    .rdata0_o (rd_instr),
    .rdata1_o (rd_data)
  );

  assign mem_bus.instruction = sel_q ? rd_instr : NOP;
  assign mem_bus.data        = sel_q ? rd_data : '0;
  assign mem_bus.cpu_hold    = (state_q != StRun);
  assign mem_bus.busy        = (state_q == StClear);
  assign mem_bus.load_ready  = (state_q == StLoad) && !full;
  assign mem_bus.prog_len    = prog_len_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: a reference memory image predicts fetch results,
// which are queued on each address drive and compared one cycle later.
module tb_prog_mem_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_mem_loader_if #(.AW(8), .DW(8)) bus ();

  prog_mem_loader #(
    .AW    (8),
    .DEPTH (256),
    .DW    (8),
    .NOP   (8'hFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_bus (bus)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] instr;
    logic [7:0] data;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  int         mptr  = 0;
  logic [7:0] model [256];
  exp_t       sb [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'hFF;
    mptr = 0;
  endtask

  task automatic read_check(input logic [7:0] a);
    exp_t       e;
    logic [7:0] na;
    na      = a + 8'd1;
    e.addr  = a;
    e.instr = model[a];
    e.data  = model[na];
    sb.push_back(e);
    bus.address = a;
    tick();
    e = sb.pop_front();
    check($sformatf("instr@%02h", e.addr), 32'(bus.instruction), 32'(e.instr));
    check($sformatf("data@%02h", e.addr), 32'(bus.data), 32'(e.data));
  endtask

  // Counts CLEAR cycles until LOAD (want_load) or RUN is reached, bounded.
  task automatic wait_clear_done(input logic want_load, input string tag);
    int n = 0;
    while (bus.busy && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_clear_cycles"}, 32'(n), 32'd256);
    if (want_load) check({tag, "_load_ready"}, 32'(bus.load_ready), 32'd1);
    else           check({tag, "_run"}, 32'(bus.cpu_hold), 32'd0);
  endtask

  task automatic enter_load(input string tag);
    bus.load_en = 1'b1;
    tick();
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    model_clear();
    wait_clear_done(1'b1, tag);
  endtask

  task automatic stream(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    tick();
    if (mptr < 256) model[mptr] = b;
    mptr++;
    bus.load_valid = 1'b0;
  endtask

  task automatic finish_load();
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    bus.address    = '0;
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_byte  = '0;
    model_clear();
    tick();
    check("rst_hold", 32'(bus.cpu_hold), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_ready", 32'(bus.load_ready), 32'd0);
    check("rst_len", 32'(bus.prog_len), 32'd0);
    check("rst_instr", 32'(bus.instruction), 32'hFF);
    check("rst_data", 32'(bus.data), 32'd0);
    rst = 1'b0;

    // Idle boot: sweep then RUN with an all-NOP image.
    wait_clear_done(1'b0, "boot");
    read_check(8'h10);

    // Reset with load_en high, 3-byte program.
    rst         = 1'b1;
    bus.load_en = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    wait_clear_done(1'b1, "load3");
    stream(8'hB1);
    stream(8'h2A);
    stream(8'hC0);
    finish_load();
    check("load3_len", 32'(bus.prog_len), 32'd3);
    check("load3_run", 32'(bus.cpu_hold), 32'd0);
    read_check(8'h00);
    read_check(8'h02);

    // Full 256-byte program plus overflow bytes.
    enter_load("full");
    for (int i = 0; i < 256; i++) stream(8'(i));
    check("full_ready", 32'(bus.load_ready), 32'd0);
    for (int i = 0; i < 4; i++) stream(8'hAA);
    check("full_ready_still", 32'(bus.load_ready), 32'd0);
    finish_load();
    check("full_len", 32'(bus.prog_len), 32'd256);
    read_check(8'hFF);
    read_check(8'h10);

    // Reload from RUN erases the old program.
    enter_load("reload");
    stream(8'h12);
    finish_load();
    check("reload_len", 32'(bus.prog_len), 32'd1);
    read_check(8'h00);
    read_check(8'h01);

    // load_valid on the same cycle load_en drops is not written.
    enter_load("drop");
    stream(8'h77);
    bus.load_valid = 1'b1;
    bus.load_byte  = 8'h55;
    bus.load_en    = 1'b0;
    tick();
    bus.load_valid = 1'b0;
    check("drop_len", 32'(bus.prog_len), 32'd1);
    read_check(8'h01);
    read_check(8'h00);

    // Reset mid-LOAD at ptr=5.
    enter_load("abort");
    for (int i = 0; i < 5; i++) stream(8'(8'h40 + i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd1);
    check("abort_hold", 32'(bus.cpu_hold), 32'd1);
    check("abort_ready", 32'(bus.load_ready), 32'd0);
    check("abort_len", 32'(bus.prog_len), 32'd0);
    check("abort_instr", 32'(bus.instruction), 32'hFF);
    check("abort_data", 32'(bus.data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
